// File: rtl/vga_palette_update_scheduler.sv
// Palette RAM port arbiter: pixel lookups during active video, buffered host
// palette writes committed only once blanking has been stable for GUARD cycles.
module vga_palette_update_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int GUARD      = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         blank,
    input  logic [7:0]                   pixel_index,
    input  logic                         true_color,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [7:0]                   wr_addr,
    input  logic [23:0]                  wr_data,
    output logic [7:0]                   ram_address,
    output logic                         ram_we,
    output logic [23:0]                  ram_wdata,
    input  logic [23:0]                  ram_q,
    output logic [23:0]                  q,
    output logic [$clog2(FIFO_DEPTH):0]  pending
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(GUARD + 1) + 1;

    typedef struct packed {
        logic [7:0]  addr;
        logic [23:0] data;
    } wr_entry_t;

    typedef enum logic [1:0] {S_VIDEO, S_GUARD, S_UPDATE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] guard_cnt;

    wr_entry_t     fifo_mem [FIFO_DEPTH];
    wr_entry_t     head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, fifo_empty;

    logic [7:0]    pix_d;
    logic          tc_d, blank_d;

    // ---------------- host write FIFO ----------------
    assign wr_ready   = (pending != (AW+1)'(FIFO_DEPTH));
    assign push       = wr_valid & wr_ready;
    assign fifo_empty = (pending == '0);
    assign head       = fifo_mem[rd_ptr];

    // Gating with live blank keeps the falling-edge cycle write-free.
    assign ram_we      = (state == S_UPDATE) & blank & ~fifo_empty;
    assign pop         = ram_we;
    assign ram_address = ram_we ? head.addr : pixel_index;
    assign ram_wdata   = ram_we ? head.data : '0;

    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr] <= '{addr: wr_addr, data: wr_data};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
        end
    end

    // ---------------- blanking state machine ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_VIDEO;
            guard_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == S_VIDEO)
                guard_cnt <= CW'(GUARD - 1);
            else if (state == S_GUARD && guard_cnt != '0)
                guard_cnt <= guard_cnt - 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_VIDEO:
                if (blank) state_n = (GUARD > 1) ? S_GUARD : S_UPDATE;
            S_GUARD:
                // Leave on the cycle the count reaches zero so the first
                // commit lands on blank cycle GUARD+1.
                if (!blank)                      state_n = S_VIDEO;
                else if (guard_cnt <= CW'(1))    state_n = S_UPDATE;
            S_UPDATE:
                if (!blank) state_n = S_VIDEO;
            default:
                state_n = S_VIDEO;
        endcase
    end

    // ---------------- colour pipeline ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pix_d   <= '0;
            tc_d    <= 1'b0;
            blank_d <= 1'b0;
            q       <= '0;
        end else begin
            pix_d   <= pixel_index;
            tc_d    <= true_color;
            blank_d <= blank;
            if (blank_d)
                q <= '0;
            else if (tc_d)
                q <= {pix_d[1:0], 6'b0, pix_d[4:2], 5'b0, pix_d[7:5], 5'b0};
            else
                q <= ram_q;
        end
    end

endmodule

// File: tb/tb_vga_palette_update_scheduler.sv
// Bench for vga_palette_update_scheduler: behavioural model (queue + blank run
// length + shadow palette) compared every cycle, plus directed literal checks.
module tb_vga_palette_update_scheduler;
    localparam int FIFO_DEPTH = 4;
    localparam int GUARD      = 2;

    logic        clock = 1'b0;
    logic        reset_n, blank, true_color, wr_valid, wr_ready, ram_we;
    logic [7:0]  pixel_index, wr_addr, ram_address;
    logic [23:0] wr_data, ram_wdata, ram_q, q;
    logic [2:0]  pending;

    logic [23:0] ram    [256];
    logic [23:0] shadow [256];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    vga_palette_update_scheduler #(.FIFO_DEPTH(FIFO_DEPTH), .GUARD(GUARD)) dut (
        .clock(clock), .reset_n(reset_n), .blank(blank), .pixel_index(pixel_index),
        .true_color(true_color), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .ram_address(ram_address),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q), .q(q), .pending(pending)
    );

    // Single-port palette RAM with registered read (old data on write).
    always @(posedge clock) begin
        if (ram_we) ram[ram_address] <= ram_wdata;
        ram_q <= ram[ram_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] tc_rgb(input logic [7:0] p);
        int b, g, r;
        b = (int'(p) % 4) * 64;
        g = ((int'(p) / 4) % 8) * 32;
        r = (int'(p) / 32) * 32;
        return 24'((b << 16) | (g << 8) | r);
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] mq [$];
    int          run;
    int          sz;
    bit          exp_we;
    logic [31:0] hd;
    logic [23:0] eq_cur, eq_nxt;

    always @(negedge clock) begin
        if (!reset_n) begin
            chk("rst_ram_we", 32'(ram_we), 32'(0));
            chk("rst_pending", 32'(pending), 32'(0));
            chk("rst_wr_ready", 32'(wr_ready), 32'(1));
            chk("rst_q", 32'(q), 32'(0));
            chk("rst_ram_wdata", 32'(ram_wdata), 32'(0));
            chk("rst_ram_address", 32'(ram_address), 32'(pixel_index));
            mq.delete();
            run    = 0;
            eq_cur = '0;
            eq_nxt = shadow[pixel_index];
        end else begin
            run    = blank ? ((run < 1000) ? run + 1 : run) : 0;
            sz     = mq.size();
            exp_we = blank && (run >= GUARD + 1) && (sz > 0);
            hd     = (sz > 0) ? mq[0] : 32'(0);
            chk("ram_we", 32'(ram_we), 32'(exp_we));
            if (exp_we) begin
                chk("ram_address", 32'(ram_address), 32'(hd[31:24]));
                chk("ram_wdata", 32'(ram_wdata), 32'(hd[23:0]));
            end else begin
                chk("ram_address", 32'(ram_address), 32'(pixel_index));
            end
            chk("wr_ready", 32'(wr_ready), 32'(sz != FIFO_DEPTH));
            chk("pending", 32'(pending), 32'(sz));
            chk("q", 32'(q), 32'(eq_cur));
            eq_cur = eq_nxt;
            eq_nxt = blank ? 24'h0 : (true_color ? tc_rgb(pixel_index) : shadow[pixel_index]);
            if (exp_we) begin
                shadow[hd[31:24]] = hd[23:0];
                void'(mq.pop_front());
            end
            if (wr_valid && sz != FIFO_DEPTH) mq.push_back({wr_addr, wr_data});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [23:0] d);
        int n = 0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clock);
        while (!wr_ready && n < 100) begin @(negedge clock); n++; end
        chk("push_ready", 32'(wr_ready), 32'(1));
        @(posedge clock); #1;
        wr_valid = 1'b0;
    endtask

    logic [9:0]  we_mask;
    logic [7:0]  adr [10];
    logic [23:0] d6 [4];
    logic [23:0] old41;

    initial begin
        reset_n = 1'b0; blank = 1'b0; pixel_index = 8'h00; true_color = 1'b0;
        wr_valid = 1'b0; wr_addr = 8'h00; wr_data = 24'h0;
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 24'($urandom);
            shadow[i] = ram[i];
        end
        ram[8'h12] = 24'h00FF00; shadow[8'h12] = 24'h00FF00;
        step(3);
        chk("reset_pending", 32'(pending), 32'(0));
        chk("reset_wr_ready", 32'(wr_ready), 32'(1));
        chk("reset_q", 32'(q), 32'(0));
        reset_n = 1'b1;

        // Plain lookup, 2-cycle latency.
        pixel_index = 8'h12;
        step(2);
        chk("lookup_q", 32'(q), 32'h00FF00);
        chk("lookup_pending", 32'(pending), 32'(0));
        chk("lookup_wr_ready", 32'(wr_ready), 32'(1));

        // Three writes in video, committed on blank cycles 3..5.
        push(8'h01, 24'hAAAAAA);
        push(8'h02, 24'hBBBBBB);
        push(8'h01, 24'hCCCCCC);
        chk("queued_pending", 32'(pending), 32'(3));
        blank = 1'b1;
        for (int k = 0; k < 10; k++) begin
            we_mask[k] = ram_we;
            adr[k]     = ram_address;
            step(1);
        end
        chk("commit_mask", 32'(we_mask), 32'(10'b0000011100));
        chk("commit_order", 32'({adr[2], adr[3], adr[4]}), 32'h010201);
        chk("ram_01", 32'(ram[8'h01]), 32'hCCCCCC);
        chk("ram_02", 32'(ram[8'h02]), 32'hBBBBBB);
        chk("drained_pending", 32'(pending), 32'(0));
        blank = 1'b0; pixel_index = 8'h01;
        step(3);
        chk("q_new_colour", 32'(q), 32'hCCCCCC);

        // Overfill, push+pop, and blank falling mid-drain.
        for (int i = 0; i < 4; i++) push(8'(8'h20 + i), 24'($urandom));
        chk("full_ready", 32'(wr_ready), 32'(0));
        chk("full_pending", 32'(pending), 32'(4));
        wr_valid = 1'b1; wr_addr = 8'h30; wr_data = 24'h303030;
        step(3);
        chk("full_hold", 32'(pending), 32'(4));
        blank = 1'b1;
        step(2);
        chk("b3_we", 32'(ram_we), 32'(1));
        step(1);
        chk("b4_ready", 32'(wr_ready), 32'(1));
        chk("b4_we", 32'(ram_we), 32'(1));
        step(1);
        chk("push_pop_pending", 32'(pending), 32'(3));
        wr_valid = 1'b0;
        step(1);
        blank = 1'b0;
        #1;
        chk("fall_no_we", 32'(ram_we), 32'(0));
        chk("fall_pending", 32'(pending), 32'(2));
        step(3);
        chk("video_pending", 32'(pending), 32'(2));
        blank = 1'b1; step(8);
        blank = 1'b0; step(2);
        chk("redrain_pending", 32'(pending), 32'(0));
        chk("ram_30", 32'(ram[8'h30]), 32'h303030);

        // True-colour bypass and blank-to-zero latency.
        true_color = 1'b1; pixel_index = 8'hE3;
        step(2);
        chk("tc_q", 32'(q), 32'hC000E0);
        blank = 1'b1;
        step(1);
        chk("blank_lat1", 32'(q), 32'hC000E0);
        step(1);
        chk("blank_q0", 32'(q), 32'(0));
        blank = 1'b0; true_color = 1'b0;
        step(3);

        // Reset in the middle of UPDATE.
        for (int i = 0; i < 4; i++) begin
            d6[i] = 24'($urandom);
            push(8'(8'h40 + i), d6[i]);
        end
        old41 = ram[8'h41];
        blank = 1'b1;
        step(3);
        chk("pre_reset_pending", 32'(pending), 32'(3));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_pending", 32'(pending), 32'(0));
        chk("mid_rst_q", 32'(q), 32'(0));
        chk("mid_rst_we", 32'(ram_we), 32'(0));
        chk("mid_rst_ready", 32'(wr_ready), 32'(1));
        step(2);
        reset_n = 1'b1; blank = 1'b0;
        chk("kept_40", 32'(ram[8'h40]), 32'(d6[0]));
        chk("untouched_41", 32'(ram[8'h41]), 32'(old41));
        step(2);

        // Randomized video/blank segments.
        for (int seg = 0; seg < 160; seg++) begin
            int vl, bl;
            vl = $urandom_range(1, 8);
            bl = $urandom_range(1, 12);
            for (int c = 0; c < vl + bl; c++) begin
                blank       = (c >= vl);
                pixel_index = 8'($urandom);
                true_color  = ($urandom_range(0, 3) == 0);
                wr_valid    = ($urandom_range(0, 1) == 1);
                wr_addr     = 8'($urandom_range(0, 15));
                wr_data     = 24'($urandom);
                step(1);
            end
            if ($urandom_range(0, 39) == 0) begin
                reset_n = 1'b0; step(2); reset_n = 1'b1;
            end
        end
        wr_valid = 1'b0; blank = 1'b0;
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
